// File: rtl/cuckoo_ring_scheduler_if.sv
// Bundle between time-compare/buttons and the ring scheduler:
// trigger and button inputs in, buzzer gate and status flags out.
interface cuckoo_ring_scheduler_if;
  logic       alarm_match;
  logic       alarm_enable;
  logic       hour_strobe;
  logic [3:0] hour;
  logic       dismiss;
  logic       snooze;
  logic       ring_en;
  logic       alarm_active;
  logic       chime_active;
  logic       snoozed;

  modport master (
    output alarm_match,
    output alarm_enable,
    output hour_strobe,
    output hour,
    output dismiss,
    output snooze,
    input  ring_en,
    input  alarm_active,
    input  chime_active,
    input  snoozed
  );

  modport slave (
    input  alarm_match,
    input  alarm_enable,
    input  hour_strobe,
    input  hour,
    input  dismiss,
    input  snooze,
    output ring_en,
    output alarm_active,
    output chime_active,
    output snoozed
  );
endinterface

// File: rtl/cuckoo_ring_scheduler.sv
// Buzzer arbiter: daily alarm (snooze, dismiss, timeout) versus the
// hourly cuckoo chime; the alarm always wins.
module cuckoo_ring_scheduler #(
  parameter int TICK_DIV     = 1000,
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_TICKS = 300,
  parameter int CHIME_ON     = 2,
  parameter int CHIME_OFF    = 2
) (
  input  logic clk,
  input  logic reset,
  cuckoo_ring_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    Idle,
    Alarm,
    Snooze,
    ChimeOn,
    ChimeOff
  } state_t;

  localparam logic [15:0] DivLast =
    16'(TICK_DIV - 1);
  localparam logic [15:0] RingLast =
    16'(RING_TIMEOUT - 1);
  localparam logic [15:0] SnoozeLast =
    16'(SNOOZE_TICKS - 1);
  localparam logic [15:0] OnLast =
    16'(CHIME_ON - 1);
  localparam logic [15:0] OffLast =
    16'(CHIME_OFF - 1);

  state_t      state;
  state_t      nextState;
  logic [15:0] divCnt;
  logic [15:0] tickCnt;
  logic [15:0] lastTick;
  logic        tick;
  logic        done;
  logic [3:0]  calls;
  logic [3:0]  callsNext;
  logic [3:0]  pendHour;
  logic [3:0]  pendHourNext;
  logic [3:0]  hourFix;
  logic        pend;
  logic        pendNext;
  logic        src;
  logic        srcQ;
  logic        trigPulse;
  logic        ringEn;
  logic        alarmAct;
  logic        chimeAct;
  logic        snoozeAct;
  logic        ringEnD;
  logic        alarmActD;
  logic        chimeActD;
  logic        snoozeActD;

  assign src  = bus.alarm_match & bus.alarm_enable;
  assign tick = (divCnt == DivLast);
  assign done = tick && (tickCnt == lastTick);

  assign hourFix =
    (bus.hour == 4'd0 || bus.hour > 4'd12)
      ? 4'd12 : bus.hour;

  always_comb begin
    lastTick = '0;
    unique case (state)
      Alarm:    lastTick = RingLast;
      Snooze:   lastTick = SnoozeLast;
      ChimeOn:  lastTick = OnLast;
      ChimeOff: lastTick = OffLast;
      default:  lastTick = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= Idle;
    end else begin
      state <= nextState;
    end
  end

  // Divider restarts on every state change so each
  // state sees its first tick a full period after entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt  <= '0;
      tickCnt <= '0;
    end else if (nextState != state) begin
      divCnt  <= '0;
      tickCnt <= '0;
    end else if (tick) begin
      divCnt  <= '0;
      tickCnt <= tickCnt + 16'd1;
    end else begin
      divCnt  <= divCnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srcQ      <= 1'b0;
      trigPulse <= 1'b0;
      calls     <= '0;
      pend      <= 1'b0;
      pendHour  <= '0;
    end else begin
      srcQ      <= src;
      trigPulse <= src & ~srcQ;
      calls     <= callsNext;
      pend      <= pendNext;
      pendHour  <= pendHourNext;
    end
  end

  always_comb begin
    nextState    = state;
    callsNext    = calls;
    pendNext     = pend;
    pendHourNext = pendHour;
    unique case (state)
      Idle: begin
        if (trigPulse) begin
          nextState = Alarm;
          if (bus.hour_strobe) begin
            pendNext     = 1'b1;
            pendHourNext = hourFix;
          end
        end else if (bus.hour_strobe || pend) begin
          nextState = ChimeOn;
          callsNext = bus.hour_strobe
                        ? hourFix : pendHour;
          pendNext  = 1'b0;
        end
      end
      Alarm: begin
        if (bus.hour_strobe) begin
          pendNext     = 1'b1;
          pendHourNext = hourFix;
        end
        if (bus.dismiss || !bus.alarm_enable)
          nextState = Idle;
        else if (bus.snooze)
          nextState = Snooze;
        else if (done)
          nextState = Idle;
      end
      Snooze: begin
        if (bus.hour_strobe) begin
          pendNext     = 1'b1;
          pendHourNext = hourFix;
        end
        if (bus.dismiss || !bus.alarm_enable)
          nextState = Idle;
        else if (done)
          nextState = Alarm;
      end
      ChimeOn: begin
        if (trigPulse) begin
          nextState = Alarm;
        end else if (bus.dismiss) begin
          nextState = Idle;
          pendNext  = 1'b0;
        end else if (done) begin
          nextState = ChimeOff;
        end
      end
      ChimeOff: begin
        if (trigPulse) begin
          nextState = Alarm;
        end else if (bus.dismiss) begin
          nextState = Idle;
          pendNext  = 1'b0;
        end else if (done) begin
          callsNext = calls - 4'd1;
          nextState = (calls == 4'd1)
                        ? Idle : ChimeOn;
        end
      end
      default: nextState = Idle;
    endcase
  end

  always_comb begin
    ringEnD    = (nextState == Alarm) ||
                 (nextState == ChimeOn);
    alarmActD  = (nextState == Alarm) ||
                 (nextState == Snooze);
    chimeActD  = (nextState == ChimeOn) ||
                 (nextState == ChimeOff);
    snoozeActD = (nextState == Snooze);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ringEn    <= 1'b0;
      alarmAct  <= 1'b0;
      chimeAct  <= 1'b0;
      snoozeAct <= 1'b0;
    end else begin
      ringEn    <= ringEnD;
      alarmAct  <= alarmActD;
      chimeAct  <= chimeActD;
      snoozeAct <= snoozeActD;
    end
  end

  assign bus.ring_en      = ringEn;
  assign bus.alarm_active = alarmAct;
  assign bus.chime_active = chimeAct;
  assign bus.snoozed      = snoozeAct;

endmodule

// File: tb/tb_cuckoo_ring_scheduler.sv
// Bench for cuckoo_ring_scheduler: directed sequences, a chime
// table and random traffic against a cycle-countdown model.
module tb_cuckoo_ring_scheduler;
  localparam int TD   = 4;
  localparam int RT   = 3;
  localparam int ST   = 5;
  localparam int CON  = 2;
  localparam int COFF = 2;
  localparam int CALL = (CON + COFF) * TD;

  logic clk;
  logic reset;
  cuckoo_ring_scheduler_if bus ();

  cuckoo_ring_scheduler #(
    .TICK_DIV(TD),
    .RING_TIMEOUT(RT),
    .SNOOZE_TICKS(ST),
    .CHIME_ON(CON),
    .CHIME_OFF(COFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef enum int {
    MIdle, MAlarm, MSnooze, MOn, MOff
  } mode_t;

  mode_t mMode = MIdle;
  int    mLeft = 0;
  int    mCalls = 0;
  int    mPendHour = 0;
  bit    mPend = 1'b0;
  bit    mPrevSrc = 1'b0;
  bit    mTrigD = 1'b0;

  typedef struct {
    logic [3:0] hour;
    int         calls;
    int         len;
  } chimeVec_t;

  chimeVec_t vecs[5];

  function automatic int fixHour(int h);
    return (h < 1 || h > 12) ? 12 : h;
  endfunction

  // Length of each mode in clock cycles.
  function automatic int durOf(mode_t m);
    case (m)
      MAlarm:  return RT * TD;
      MSnooze: return ST * TD;
      MOn:     return CON * TD;
      MOff:    return COFF * TD;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] expOut();
    return {mMode == MAlarm || mMode == MOn,
            mMode == MAlarm || mMode == MSnooze,
            mMode == MOn || mMode == MOff,
            mMode == MSnooze};
  endfunction

  function automatic void latchPend();
    if (bus.hour_strobe) begin
      mPend = 1'b1;
      mPendHour = fixHour(int'(bus.hour));
    end
  endfunction

  function automatic void modelStep();
    bit    s;
    bit    trig;
    bit    last;
    mode_t nxt;
    if (reset) begin
      mMode = MIdle; mLeft = 0; mCalls = 0;
      mPend = 1'b0; mPendHour = 0;
      mPrevSrc = 1'b0; mTrigD = 1'b0;
      return;
    end
    s    = bus.alarm_match & bus.alarm_enable;
    trig = mTrigD;
    last = (mLeft == 1);
    nxt  = mMode;
    case (mMode)
      MIdle:
        if (trig) begin
          nxt = MAlarm;
          latchPend();
        end else if (bus.hour_strobe) begin
          nxt = MOn;
          mCalls = fixHour(int'(bus.hour));
          mPend = 1'b0;
        end else if (mPend) begin
          nxt = MOn;
          mCalls = mPendHour;
          mPend = 1'b0;
        end
      MAlarm: begin
        latchPend();
        if (bus.dismiss || !bus.alarm_enable) nxt = MIdle;
        else if (bus.snooze) nxt = MSnooze;
        else if (last) nxt = MIdle;
      end
      MSnooze: begin
        latchPend();
        if (bus.dismiss || !bus.alarm_enable) nxt = MIdle;
        else if (last) nxt = MAlarm;
      end
      default:
        if (trig) nxt = MAlarm;
        else if (bus.dismiss) begin
          nxt = MIdle;
          mPend = 1'b0;
        end else if (last && mMode == MOn) nxt = MOff;
        else if (last) begin
          mCalls--;
          nxt = (mCalls == 0) ? MIdle : MOn;
        end
    endcase
    if (nxt != mMode) mLeft = durOf(nxt);
    else mLeft--;
    mMode = nxt;
    mTrigD = s & ~mPrevSrc;
    mPrevSrc = s;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic cyc();
    logic [3:0] got;
    logic [3:0] exp;
    @(posedge clk);
    modelStep();
    #1;
    got = {bus.ring_en, bus.alarm_active,
           bus.chime_active, bus.snoozed};
    exp = expOut();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL model t=%0t got %b expected %b",
               $time, got, exp);
    end
  endtask

  task automatic strobe(int h);
    bus.hour = 4'(h);
    bus.hour_strobe = 1'b1;
    cyc();
    bus.hour_strobe = 1'b0;
  endtask

  task automatic raiseAlarm();
    bus.alarm_match = 1'b1;
    cyc();
    cyc();
    bus.alarm_match = 1'b0;
  endtask

  task automatic runChime(output int pulses,
                          output int len,
                          output int hi);
    logic prev;
    pulses = 0; len = 0; hi = 0; prev = 1'b0;
    for (int i = 0; i < 400 && bus.chime_active; i++) begin
      len++;
      if (bus.ring_en && !prev) pulses++;
      if (i < CALL && bus.ring_en) hi++;
      prev = bus.ring_en;
      cyc();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p;
    int l;
    int h;
    vecs[0] = '{4'd3,  3,  3 * CALL};
    vecs[1] = '{4'd0,  12, 12 * CALL};
    vecs[2] = '{4'd1,  1,  1 * CALL};
    vecs[3] = '{4'd13, 12, 12 * CALL};
    vecs[4] = '{4'd7,  7,  7 * CALL};

    reset = 1'b1;
    bus.alarm_match = 1'b0;
    bus.alarm_enable = 1'b1;
    bus.hour_strobe = 1'b0;
    bus.hour = 4'd0;
    bus.dismiss = 1'b0;
    bus.snooze = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    check("reset_outs",
          int'({bus.ring_en, bus.alarm_active,
                bus.chime_active, bus.snoozed}), 0);

    // Alarm latency, timeout length, no retrigger on held match.
    bus.alarm_match = 1'b1;
    cyc();
    check("alarm_lat_k1", int'(bus.ring_en), 0);
    cyc();
    check("alarm_lat_k2", int'(bus.ring_en), 1);
    n = 0;
    for (int i = 0; i < 40 && bus.ring_en; i++) begin
      n++;
      cyc();
    end
    check("alarm_timeout_len", n, RT * TD);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (bus.ring_en) n++;
    end
    check("alarm_no_retrigger", n, 0);
    bus.alarm_match = 1'b0;
    cyc();

    // Snooze, ignored second snooze, resume, dismiss.
    raiseAlarm();
    cyc();
    bus.snooze = 1'b1;
    cyc();
    bus.snooze = 1'b0;
    check("snooze_ring_off", int'(bus.ring_en), 0);
    check("snooze_flag", int'(bus.snoozed), 1);
    n = 0;
    for (int i = 0; i < 100 && bus.snoozed; i++) begin
      n++;
      bus.snooze = (n == 5);
      cyc();
    end
    bus.snooze = 1'b0;
    check("snooze_len", n, ST * TD);
    check("snooze_resume", int'(bus.ring_en), 1);
    cyc();
    bus.dismiss = 1'b1;
    cyc();
    bus.dismiss = 1'b0;
    check("dismiss_outs",
          int'({bus.ring_en, bus.alarm_active,
                bus.chime_active, bus.snoozed}), 0);
    cyc();

    // Chime table: call count, total length, first call high time.
    foreach (vecs[k]) begin
      strobe(int'(vecs[k].hour));
      runChime(p, l, h);
      check($sformatf("chime_calls_h%0d", vecs[k].hour),
            p, vecs[k].calls);
      check($sformatf("chime_len_h%0d", vecs[k].hour),
            l, vecs[k].len);
      check($sformatf("chime_high_h%0d", vecs[k].hour),
            h, CON * TD);
      cyc();
    end

    // Alarm aborts chime; strobe in ALARM queues one call.
    strobe(12);
    repeat (4) cyc();
    raiseAlarm();
    check("prio_alarm", int'(bus.alarm_active), 1);
    check("prio_chime_gone", int'(bus.chime_active), 0);
    cyc();
    strobe(1);
    cyc();
    bus.dismiss = 1'b1;
    cyc();
    bus.dismiss = 1'b0;
    check("prio_dismissed", int'(bus.alarm_active), 0);
    cyc();
    runChime(p, l, h);
    check("prio_pending_calls", p, 1);
    check("prio_pending_len", l, CALL);
    cyc();

    // Dismiss and snooze together in ALARM.
    raiseAlarm();
    cyc();
    bus.dismiss = 1'b1;
    bus.snooze = 1'b1;
    cyc();
    bus.dismiss = 1'b0;
    bus.snooze = 1'b0;
    check("dis_snz_state",
          int'({bus.alarm_active, bus.snoozed}), 0);
    cyc();

    // Alarm trigger and strobe in the same IDLE cycle.
    bus.alarm_match = 1'b1;
    cyc();
    bus.hour_strobe = 1'b1;
    bus.hour = 4'd2;
    cyc();
    bus.hour_strobe = 1'b0;
    bus.alarm_match = 1'b0;
    check("simul_alarm", int'(bus.alarm_active), 1);
    check("simul_no_chime", int'(bus.chime_active), 0);
    cyc();
    bus.dismiss = 1'b1;
    cyc();
    bus.dismiss = 1'b0;
    cyc();
    check("simul_chime_after", int'(bus.chime_active), 1);
    runChime(p, l, h);
    check("simul_chime_calls", p, 2);
    cyc();

    // Disable in ALARM keeps the pending chime.
    raiseAlarm();
    strobe(2);
    bus.alarm_enable = 1'b0;
    cyc();
    check("disable_idle", int'(bus.alarm_active), 0);
    bus.alarm_enable = 1'b1;
    cyc();
    check("disable_keeps_pend", int'(bus.chime_active), 1);
    runChime(p, l, h);
    check("disable_pend_calls", p, 2);
    cyc();

    // Reset mid-ALARM with a pending chime, then mid-CHIME.
    raiseAlarm();
    strobe(5);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_alarm_outs",
          int'({bus.ring_en, bus.alarm_active,
                bus.chime_active, bus.snoozed}), 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.chime_active) n++;
    end
    check("rst_no_pending", n, 0);
    strobe(4);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_chime_outs",
          int'({bus.ring_en, bus.alarm_active,
                bus.chime_active, bus.snoozed}), 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.ring_en) n++;
    end
    check("rst_chime_quiet", n, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0)
        bus.alarm_match = ~bus.alarm_match;
      bus.alarm_enable = ($urandom_range(0, 199) != 0);
      bus.hour_strobe = ($urandom_range(0, 59) == 0);
      bus.hour = 4'($urandom_range(0, 15));
      bus.dismiss = ($urandom_range(0, 79) == 0);
      bus.snooze = ($urandom_range(0, 29) == 0);
      cyc();
    end
    reset = 1'b0;
    bus.alarm_match = 1'b0;
    bus.alarm_enable = 1'b1;
    bus.hour_strobe = 1'b0;
    bus.dismiss = 1'b0;
    bus.snooze = 1'b0;
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
